// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_decoder
//  Function : Monitors the active-low anode/cathode lines of a multiplexed
//             8-digit seven-segment display. It rebuilds the 32-bit hex value
//             on display and reports it once every digit has been seen
//             stable within one frame.
//  Revision : 1.0  initial release
// ============================================================================
module seven_segment_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  an_in,
    input  logic [6:0]  cat_in,
    output logic [31:0] val_out,
    output logic        valid_out,
    output logic        seg_err_out,
    output logic        stale_out,
    output logic [7:0]  digit_mask_out
);

    localparam int                    c_to_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_width-1:0] c_to_limit = c_to_width'(TIMEOUT_CYCLES);
    localparam logic [c_to_width-1:0] c_to_last  = c_to_width'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]           c_settle   = 16'(SETTLE_CYCLES);

    // Reset bridge: assertion takes effect at once, release is aligned to clk_in
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Two-flop synchronizers plus a copy of the previous synced sample
    logic [7:0] r_an_meta, r_an_sync, r_an_prev;
    logic [6:0] r_cat_meta, r_cat_sync, r_cat_prev;

    // Dwell tracking
    logic [15:0] r_stab_cnt;
    logic        r_captured;

    // Frame assembly and outputs
    logic [31:0]           r_asm;
    logic [7:0]            r_mask;
    logic                  r_frame_err;
    logic [31:0]           r_val;
    logic                  r_valid;
    logic                  r_seg_err;
    logic                  r_stale;
    logic [c_to_width-1:0] r_to_cnt;

    // Combinational helpers
    logic [6:0]  w_seg;
    logic [3:0]  w_nib;
    logic        w_inv;
    logic [7:0]  w_an_sel;
    logic        w_an_onehot;
    logic [2:0]  w_idx;
    logic        w_an_changed;
    logic        w_changed;
    logic [15:0] w_stab_next;
    logic        w_captured_eff;
    logic        w_capture;
    logic [7:0]  w_mask_upd;
    logic        w_frame_done;
    logic [31:0] w_word_upd;
    logic        w_to_hit;

    // Reset bridge register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Input synchronizers and previous-sample copy; idle lines are all high
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_an_meta  <= 8'hFF;
            r_an_sync  <= 8'hFF;
            r_an_prev  <= 8'hFF;
            r_cat_meta <= 7'h7F;
            r_cat_sync <= 7'h7F;
            r_cat_prev <= 7'h7F;
        end else begin
            r_an_meta  <= an_in;
            r_an_sync  <= r_an_meta;
            r_an_prev  <= r_an_sync;
            r_cat_meta <= cat_in;
            r_cat_sync <= r_cat_meta;
            r_cat_prev <= r_cat_sync;
        end
    end

    assign w_seg = ~r_cat_sync;

    // Segment pattern {g,f,e,d,c,b,a} to hex nibble; unknown patterns flag invalid
    always_comb begin
        w_nib = 4'h0;
        w_inv = 1'b0;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: begin
                w_nib = 4'h0;
                w_inv = 1'b1;
            end
        endcase
    end

    assign w_an_sel    = ~r_an_sync;
    assign w_an_onehot = $onehot(w_an_sel);

    // Index of the selected digit; only meaningful when the anode is one-hot
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an_sel[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // The counter value written this edge is the number of cycles the pair has
    // held; a capture fires on the edge that writes SETTLE_CYCLES.
    assign w_an_changed   = (r_an_sync != r_an_prev);
    assign w_changed      = w_an_changed || (r_cat_sync != r_cat_prev);
    assign w_stab_next    = w_changed ? 16'd0 :
                            ((r_stab_cnt == 16'hFFFF) ? r_stab_cnt : r_stab_cnt + 16'd1);
    assign w_captured_eff = r_captured && !w_an_changed;
    assign w_capture      = (w_stab_next == c_settle) && w_an_onehot && !w_captured_eff;

    assign w_mask_upd   = r_mask | (8'b0000_0001 << w_idx);
    assign w_frame_done = w_capture && (w_mask_upd == 8'hFF);

    // Assembled word with the current nibble dropped into its slot
    always_comb begin
        w_word_upd = r_asm;
        w_word_upd[{w_idx, 2'b00} +: 4] = w_nib;
    end

    // A capture on the same edge always wins over the timeout
    assign w_to_hit = !w_capture && (r_to_cnt == c_to_last);

    // Stability counter and one-capture-per-dwell flag
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stab_cnt <= 16'd0;
            r_captured <= 1'b0;
        end else begin
            r_stab_cnt <= w_stab_next;
            r_captured <= w_capture | w_captured_eff;
        end
    end

    // Timeout counter: restarts on every capture, parks at the limit
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_capture) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_to_limit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Frame assembly, completion publishing and stale handling
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_asm       <= 32'd0;
            r_mask      <= 8'd0;
            r_frame_err <= 1'b0;
            r_val       <= 32'd0;
            r_valid     <= 1'b0;
            r_seg_err   <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_frame_done) begin
                r_val       <= w_word_upd;
                r_seg_err   <= r_frame_err | w_inv;
                r_valid     <= 1'b1;
                r_asm       <= 32'd0;
                r_mask      <= 8'd0;
                r_frame_err <= 1'b0;
                r_stale     <= 1'b0;
            end else if (w_capture) begin
                r_asm       <= w_word_upd;
                r_mask      <= w_mask_upd;
                r_frame_err <= r_frame_err | w_inv;
            end else if (w_to_hit) begin
                r_stale     <= 1'b1;
                r_asm       <= 32'd0;
                r_mask      <= 8'd0;
                r_frame_err <= 1'b0;
            end
        end
    end

    assign val_out        = r_val;
    assign valid_out      = r_valid;
    assign seg_err_out    = r_seg_err;
    assign stale_out      = r_stale;
    assign digit_mask_out = r_mask;

endmodule
`default_nettype wire
